sha_kt_bram_mc: RTL and testbench

//  Parametrised round-constant store for SHA-2 cores: Kt for SHA-256 (32-bit, 64 rounds)
//  or SHA-512 (64-bit, 80 rounds), with N_PAD leading zero words, in one block RAM.

---
 rtl/sha_kt_pkg.sv | 55 +++++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/sha_kt_bram_mc.sv | 108 ++++++++++
 tb/tb_sha_kt_bram_mc.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_kt_pkg.sv
// SHA-2 round constants and the block-RAM initial-image helper shared by the Kt store.
package sha_kt_pkg;

  localparam logic [31:0] K256 [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [63:0] K512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  function automatic int ROUNDS(int mode);
    return (mode == 512) ? 80 : 64;
  endfunction

  function automatic int WORD_W(int mode);
    return (mode == 512) ? 64 : 32;
  endfunction

  // Word at 'addr' of the power-up image: zero padding, then K[0..ROUNDS-1], then zeros.
  function automatic logic [63:0] init_word(int mode, int n_pad, int addr);
    int j;
    j = addr - n_pad;
    if (j < 0 || j >= ROUNDS(mode)) return 64'h0;
    if (mode == 512) return K512[7'(j)];
    return {32'h0, K256[6'(j)]};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;

  // Pass 0 scans channels at/after the pointer, pass 1 wraps to those before it.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 0; c < N; c++) begin
        if (!found && req_i[c] && ((PW'(c) >= ptr_q) == (pass == 0))) begin
          found      = 1'b1;
          grant_o[c] = 1'b1;
          idx_o      = PW'(c);
          ptr_d      = (c == N - 1) ? '0 : PW'(c + 1);
        end
      end
    end
    if (!rst_ni) grant_o = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        ptr_q <= '0;
    else if (advance_i) ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sha_kt_bram_mc.sv
// SHA-2 Kt constant store in one block RAM, shared by N_CH channels, fixed 2-cycle read latency.
module sha_kt_bram_mc
  import sha_kt_pkg::*;
#(
  parameter  int MODE   = 256,
  parameter  int N_PAD  = 7,
  parameter  int N_CH   = 2,
  parameter  int ADDR_W = 7,
  localparam int W      = WORD_W(MODE),
  localparam int CHW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   CLK,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        req,
  input  logic [N_CH*ADDR_W-1:0] t,
  output logic [N_CH-1:0]        grant,
  output logic [W-1:0]           Kt,
  output logic                   Kt_valid,
  output logic [CHW-1:0]         Kt_ch,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [W-1:0]           wr_data
);

  localparam int ROUNDS_N = ROUNDS(MODE);
  localparam int DEPTH    = 1 << ADDR_W;

  typedef logic [W-1:0] mem_t [DEPTH];

  if (MODE != 256 && MODE != 512) begin : g_bad_mode
    $error("sha_kt_bram_mc: MODE must be 256 or 512");
  end
  if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
    $error("sha_kt_bram_mc: N_CH must be 1..8");
  end
  if (DEPTH < N_PAD + ROUNDS_N + 1) begin : g_bad_addr_w
    $error("sha_kt_bram_mc: ADDR_W too small for N_PAD + ROUNDS + 1 words");
  end

  function automatic mem_t build_image();
    mem_t img;
    for (int a = 0; a < DEPTH; a++) img[ADDR_W'(a)] = W'(init_word(MODE, N_PAD, a));
    return img;
  endfunction

  (* ram_style = "block" *) mem_t mem = build_image();

  logic [W-1:0]      mem_r_q;
  logic              vld_p1_q;
  logic [CHW-1:0]    ch_p1_q;
  logic [W-1:0]      kt_q;
  logic              kt_vld_q;
  logic [CHW-1:0]    kt_ch_q;
  logic [CHW-1:0]    gidx;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;

  rr_arbiter #(.N(N_CH)) u_arb (
    .clk_i     (CLK),
    .rst_ni    (rst_n),
    .req_i     (req),
    .advance_i (rd_en),
    .grant_o   (grant),
    .idx_o     (gidx)
  );

  assign rd_en = |grant;

  always_comb begin
    rd_addr = '0;
    for (int i = 0; i < N_CH; i++)
      if (grant[i]) rd_addr = t[i*ADDR_W +: ADDR_W];
  end

  // Stage p1: BRAM port A (read-first against port B) into the BRAM output register.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) mem_r_q <= mem[rd_addr];
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      ch_p1_q  <= '0;
    end else begin
      vld_p1_q <= rd_en;
      if (rd_en) ch_p1_q <= gidx;
    end
  end

  // Stage p2: fabric output register, data zeroed whenever no result is present.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      kt_q     <= '0;
      kt_vld_q <= 1'b0;
      kt_ch_q  <= '0;
    end else begin
      kt_vld_q <= vld_p1_q;
      kt_q     <= vld_p1_q ? mem_r_q : '0;
      if (vld_p1_q) kt_ch_q <= ch_p1_q;
    end
  end

  assign Kt       = kt_q;
  assign Kt_valid = kt_vld_q;
  assign Kt_ch    = kt_ch_q;

endmodule

// File: tb/tb_sha_kt_bram_mc.sv
// Directed and randomized checks of the shared Kt store against a table-driven model.
module tb_sha_kt_bram_mc;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  req256, grant256;
  logic [13:0] t256;
  logic [31:0] kt256;
  logic        v256;
  logic [0:0]  ch256;
  logic        wr256;
  logic [6:0]  wa256;
  logic [31:0] wd256;

  logic [1:0]  req512, grant512;
  logic [13:0] t512;
  logic [63:0] kt512;
  logic        v512;
  logic [0:0]  ch512;
  logic        wr512;
  logic [6:0]  wa512;
  logic [63:0] wd512;

  sha_kt_bram_mc #(.MODE(256), .N_PAD(7), .N_CH(2), .ADDR_W(7)) u256 (
    .CLK(clk), .rst_n(rst_n), .req(req256), .t(t256), .grant(grant256),
    .Kt(kt256), .Kt_valid(v256), .Kt_ch(ch256),
    .wr_en(wr256), .wr_addr(wa256), .wr_data(wd256)
  );

  sha_kt_bram_mc #(.MODE(512), .N_PAD(7), .N_CH(2), .ADDR_W(7)) u512 (
    .CLK(clk), .rst_n(rst_n), .req(req512), .t(t512), .grant(grant512),
    .Kt(kt512), .Kt_valid(v512), .Kt_ch(ch512),
    .wr_en(wr512), .wr_addr(wa512), .wr_data(wd512)
  );

  typedef struct packed {
    logic        v;
    logic        ch;
    logic [31:0] d;
  } res_t;

  logic [31:0] mm [128];
  int          ptr_m;
  res_t        s1_m, out_m;
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(int p, logic [1:0] r);
    for (int k = 0; k < 2; k++)
      if (r[(p + k) % 2]) return (p + k) % 2;
    return -1;
  endfunction

  // One clock of the 256 instance: inputs already set at the falling edge.
  task automatic cyc();
    int         g;
    logic [1:0] eg;
    res_t       nr;
    g  = rst_n ? pick(ptr_m, req256) : -1;
    eg = (g < 0) ? 2'b00 : (2'b01 << g);
    #1 chk("grant", {62'h0, grant256}, {62'h0, eg});
    nr = '0;
    if (g >= 0) begin
      nr.v  = 1'b1;
      nr.ch = (g == 1);
      nr.d  = mm[t256[g*7 +: 7]];
    end
    @(posedge clk);
    if (!rst_n) begin
      s1_m  = '0;
      out_m = '0;
      ptr_m = 0;
    end else begin
      out_m = s1_m;
      s1_m  = nr;
      if (g >= 0) ptr_m = (g + 1) % 2;
    end
    if (wr256) mm[wa256] = wd256;
    #1;
    chk("Kt_valid", {63'h0, v256}, {63'h0, out_m.v});
    chk("Kt", {32'h0, kt256}, {32'h0, (out_m.v ? out_m.d : 32'h0)});
    if (out_m.v) chk("Kt_ch", {63'h0, ch256}, {63'h0, out_m.ch});
    @(negedge clk);
  endtask

  task automatic rd512(int ch, logic [6:0] a, logic [63:0] exp);
    req512 = 2'b01 << ch;
    t512   = '0;
    t512[ch*7 +: 7] = a;
    #1 chk("grant512", {62'h0, grant512}, {62'h0, 2'b01 << ch});
    @(posedge clk);
    #1 req512 = 2'b00;
    chk("v512_early", {63'h0, v512}, 64'h0);
    @(posedge clk);
    #1;
    chk("v512", {63'h0, v512}, 64'h1);
    chk("Kt512", kt512, exp);
    chk("ch512", {63'h0, ch512}, ch);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req256 = '0; t256 = '0; wr256 = 1'b0; wa256 = '0; wd256 = '0;
    req512 = '0; t512 = '0; wr512 = 1'b0; wa512 = '0; wd512 = '0;
    for (int a = 0; a < 128; a++) mm[a] = (a >= 7 && a < 71) ? KT[a-7] : 32'h0;
    ptr_m = 0;
    s1_m  = '0;
    out_m = '0;

    // Reset: requests ignored, outputs held at zero.
    @(negedge clk);
    req256 = 2'b11;
    cyc();
    cyc();
    chk("rst_kt", {32'h0, kt256}, 64'h0);
    rst_n  = 1'b1;
    req256 = 2'b00;
    cyc();

    // Single read of K[0].
    req256 = 2'b01; t256 = 14'd7;
    cyc();
    req256 = 2'b00;
    cyc();
    chk("t1_kt", {32'h0, kt256}, 64'h428a2f98);
    chk("t1_v", {63'h0, v256}, 64'h1);
    chk("t1_ch", {63'h0, ch256}, 64'h0);

    // Padding, last constant, first word past the image.
    req256 = 2'b01; t256 = 14'd0;
    cyc();
    t256 = 14'd70;
    cyc();
    chk("t2_pad", {32'h0, kt256}, 64'h0);
    chk("t2_pad_v", {63'h0, v256}, 64'h1);
    t256 = 14'd71;
    cyc();
    chk("t2_k63", {32'h0, kt256}, 64'hc67178f2);
    req256 = 2'b00;
    cyc();
    chk("t2_past", {32'h0, kt256}, 64'h0);
    chk("t2_past_v", {63'h0, v256}, 64'h1);
    cyc();

    // Two channels contending: alternate grants, one result per cycle.
    req256 = 2'b10; t256 = {7'd9, 7'd0};
    cyc();
    req256 = 2'b11; t256 = {7'd9, 7'd8};
    for (int i = 0; i < 4; i++) begin
      #1 chk("t4_grant", {62'h0, grant256}, (i % 2 == 0) ? 64'h1 : 64'h2);
      cyc();
      if (i == 1) begin
        chk("t4_k1", {32'h0, kt256}, 64'h71374491);
        chk("t4_ch0", {63'h0, ch256}, 64'h0);
      end
      if (i == 2) begin
        chk("t4_k2", {32'h0, kt256}, 64'hb5c0fbcf);
        chk("t4_ch1", {63'h0, ch256}, 64'h1);
      end
    end
    req256 = 2'b00;
    cyc();
    cyc();

    // Read-first collision on port B, then the patched word.
    req256 = 2'b01; t256 = 14'd7;
    wr256 = 1'b1; wa256 = 7'd7; wd256 = 32'hdeadbeef;
    cyc();
    wr256 = 1'b0;
    cyc();
    chk("t5_old", {32'h0, kt256}, 64'h428a2f98);
    req256 = 2'b00;
    cyc();
    chk("t5_new", {32'h0, kt256}, 64'hdeadbeef);
    cyc();

    // Reset with a read in flight.
    req256 = 2'b01; t256 = 14'd8;
    cyc();
    req256 = 2'b00;
    rst_n  = 1'b0;
    #1;
    chk("t6_async_v", {63'h0, v256}, 64'h0);
    chk("t6_async_kt", {32'h0, kt256}, 64'h0);
    @(negedge clk);
    req256 = 2'b11;
    cyc();
    cyc();
    rst_n  = 1'b1;
    req256 = 2'b00;
    cyc();
    cyc();
    req256 = 2'b11; t256 = {7'd9, 7'd8};
    #1 chk("t6_ptr0", {62'h0, grant256}, 64'h1);
    cyc();
    req256 = 2'b00;
    cyc();
    cyc();

    // Randomized traffic with port-B writes.
    for (int i = 0; i < 400; i++) begin
      req256 = 2'($urandom_range(0, 3));
      t256   = 14'($urandom);
      wr256  = ($urandom_range(0, 7) == 0);
      wa256  = 7'($urandom);
      wd256  = $urandom;
      cyc();
    end
    req256 = 2'b00;
    wr256  = 1'b0;
    cyc();
    cyc();

    // SHA-512 image.
    rd512(0, 7'd7,  64'h428a2f98d728ae22);
    rd512(1, 7'd86, 64'h6c44198c4a475817);
    rd512(0, 7'd8,  64'h7137449123ef65cd);
    rd512(1, 7'd50, 64'hc76c51a30654be30);
    rd512(0, 7'd0,  64'h0);
    rd512(1, 7'd87, 64'h0);
    wr512 = 1'b1; wa512 = 7'd100; wd512 = {$urandom, $urandom};
    @(posedge clk);
    #1 wr512 = 1'b0;
    @(negedge clk);
    rd512(1, 7'd100, wd512);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
